// File: rtl/mac_pkg.sv
// Shared op encoding and default widths for the MAC accumulator slice.
package mac_pkg;

  localparam int unsigned PROD_W_DEFAULT = 32;
  localparam int unsigned ACC_W_DEFAULT  = 40;
  localparam int unsigned CNT_W_DEFAULT  = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

endpackage

// File: rtl/mac_accumulator_if.sv
// Product input and accumulator output handshakes of the MAC accumulator.
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEFAULT,
  parameter int unsigned ACC_W  = ACC_W_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  op_e               op;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc;
  logic              overflow;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, product, op, out_ready,
    input  in_ready, out_valid, acc, overflow, count
  );

  modport slave (
    input  in_valid, product, op, out_ready,
    output in_ready, out_valid, acc, overflow, count
  );

endinterface

// File: rtl/acc_alu.sv
// Combinational load/add/sub/pass of a product into the accumulator, with
// overflow detection and optional clamping.
module acc_alu
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W   = PROD_W_DEFAULT,
  parameter int unsigned ACC_W    = ACC_W_DEFAULT,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  input  op_e               op,
  output logic [ACC_W-1:0]  next_acc,
  output logic              ovf_event
);

  logic [ACC_W:0] prod_x;
  logic [ACC_W:0] sum;
  logic [ACC_W:0] diff;

  // One extra bit: carry-out on add, borrow (product > acc) on subtract.
  assign prod_x = (ACC_W+1)'(product);
  assign sum    = {1'b0, acc} + prod_x;
  assign diff   = {1'b0, acc} - prod_x;

  always_comb begin
    next_acc  = acc;
    ovf_event = 1'b0;
    unique case (op)
      OP_LOAD: next_acc = ACC_W'(product);
      OP_ADD: begin
        if (sum[ACC_W]) begin
          ovf_event = 1'b1;
          next_acc  = SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end else begin
          next_acc = sum[ACC_W-1:0];
        end
      end
      OP_SUB: begin
        if (diff[ACC_W]) begin
          ovf_event = 1'b1;
          next_acc  = SATURATE ? {ACC_W{1'b0}} : diff[ACC_W-1:0];
        end else begin
          next_acc = diff[ACC_W-1:0];
        end
      end
      OP_PASS: ;
    endcase
  end

endmodule

// File: rtl/mac_accumulator.sv
// Two-stage MAC accumulator: input capture register, then accumulate/output
// register, both behind valid/ready handshakes.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W   = PROD_W_DEFAULT,
  parameter int unsigned ACC_W    = ACC_W_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT,
  parameter bit          SATURATE = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  input logic         clear,
  mac_accumulator_if.slave bus
);

  logic              s1_valid_q, s1_valid_d;
  logic [PROD_W-1:0] s1_prod_q, s1_prod_d;
  op_e               s1_op_q, s1_op_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  logic              adv;
  logic              in_ready;
  logic              accept;
  logic [ACC_W-1:0]  alu_acc;
  logic              alu_ovf;

  // Stage 2 moves whenever its output slot is empty or being consumed.
  assign adv      = s1_valid_q & (~out_valid_q | bus.out_ready);
  assign in_ready = ~clear & (~s1_valid_q | adv);
  assign accept   = bus.in_valid & in_ready;
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  acc_alu #(
    .PROD_W   (PROD_W),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_alu (
    .acc       (acc_q),
    .product   (s1_prod_q),
    .op        (s1_op_q),
    .next_acc  (alu_acc),
    .ovf_event (alu_ovf)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_prod_d   = s1_prod_q;
    s1_op_d     = s1_op_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_prod_d  = bus.product;
      s1_op_d    = bus.op;
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end

    if (adv) begin
      out_valid_d = 1'b1;
      acc_d       = alu_acc;
      unique case (s1_op_q)
        OP_LOAD: begin
          ovf_d = 1'b0;
          cnt_d = CNT_W'(1);
        end
        OP_ADD, OP_SUB: begin
          ovf_d = ovf_q | alu_ovf;
          cnt_d = cnt_inc;
        end
        OP_PASS: ;
      endcase
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_op_q     <= OP_LOAD;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.acc       = acc_q;
  assign bus.overflow  = ovf_q;
  assign bus.count     = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Drives a saturating and a wrapping mac_accumulator with identical stimulus
// and checks both against an arithmetic reference model.
module tb_mac_accumulator;
  import mac_pkg::*;

  localparam int unsigned PW = 32;
  localparam int unsigned AW = 40;
  localparam int unsigned CW = 8;
  localparam longint unsigned AMOD   = 64'h100_0000_0000;
  localparam int unsigned     CNTMAX = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  mac_accumulator_if #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) ifs ();
  mac_accumulator_if #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) ifw ();

  mac_accumulator #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW), .SATURATE(1'b1)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (ifs.slave)
  );

  mac_accumulator #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW), .SATURATE(1'b0)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (ifw.slave)
  );

  typedef struct {
    longint unsigned acc_s;
    bit              ovf_s;
    longint unsigned acc_w;
    bit              ovf_w;
    int unsigned     cnt;
  } beat_t;

  beat_t           q[$];
  longint unsigned ms_acc, mw_acc;
  bit              ms_ovf, mw_ovf;
  int unsigned     m_cnt;
  bit              m_pres, m_s1;
  int              errors = 0;
  int              checks = 0;
  int              beats  = 0;

  function automatic longint unsigned model_acc(input bit [1:0] o, input longint unsigned a,
                                                input longint unsigned p, input bit sat);
    case (o)
      2'd0: return p;
      2'd1: begin
        if (a + p >= AMOD) return sat ? AMOD - 1 : a + p - AMOD;
        return a + p;
      end
      2'd2: begin
        if (p > a) return sat ? 64'd0 : a + AMOD - p;
        return a - p;
      end
      default: return a;
    endcase
  endfunction

  function automatic bit model_ovf(input bit [1:0] o, input longint unsigned a,
                                   input longint unsigned p, input bit ov);
    case (o)
      2'd0:    return 1'b0;
      2'd1:    return ov | (a + p >= AMOD);
      2'd2:    return ov | (p > a);
      default: return ov;
    endcase
  endfunction

  function automatic int unsigned model_cnt(input bit [1:0] o, input int unsigned c);
    case (o)
      2'd0:    return 1;
      2'd3:    return c;
      default: return (c >= CNTMAX) ? CNTMAX : c + 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms_acc = 0; mw_acc = 0; ms_ovf = 0; mw_ovf = 0; m_cnt = 0;
    m_pres = 0; m_s1 = 0;
    q.delete();
  endtask

  task automatic drive(input bit v, input bit [1:0] o, input logic [31:0] p, input bit ordy,
                       input bit clr);
    ifs.in_valid = v;  ifw.in_valid = v;
    ifs.op = op_e'(o); ifw.op = op_e'(o);
    ifs.product = p;   ifw.product = p;
    ifs.out_ready = ordy; ifw.out_ready = ordy;
    clear = clr;
  endtask

  // One clock: drive, check the pre-edge view against the model, take the edge.
  task automatic cycle(input bit v, input bit [1:0] o, input logic [31:0] p, input bit ordy,
                       input bit clr, output bit took);
    bit    exp_rdy, adv, acc_now, nso, nwo;
    beat_t b;
    drive(v, o, p, ordy, clr);
    #1;
    exp_rdy = !clr && (!m_s1 || !m_pres || ordy);
    chk("in_ready_sat", 64'(ifs.in_ready), 64'(exp_rdy));
    chk("in_ready_wrap", 64'(ifw.in_ready), 64'(exp_rdy));
    chk("out_valid_sat", 64'(ifs.out_valid), 64'(m_pres));
    chk("out_valid_wrap", 64'(ifw.out_valid), 64'(m_pres));
    if (m_pres && q.size() > 0) begin
      chk("acc_sat", 64'(ifs.acc), q[0].acc_s);
      chk("ovf_sat", 64'(ifs.overflow), 64'(q[0].ovf_s));
      chk("acc_wrap", 64'(ifw.acc), q[0].acc_w);
      chk("ovf_wrap", 64'(ifw.overflow), 64'(q[0].ovf_w));
      chk("count", 64'(ifs.count), 64'(q[0].cnt));
    end
    acc_now = v && exp_rdy;
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else begin
      adv = m_s1 && (!m_pres || ordy);
      if (m_pres && ordy) begin
        void'(q.pop_front());
        beats++;
      end
      m_pres = adv || (m_pres && !ordy);
      if (acc_now) begin
        nso = model_ovf(o, ms_acc, 64'(p), ms_ovf);
        nwo = model_ovf(o, mw_acc, 64'(p), mw_ovf);
        ms_acc = model_acc(o, ms_acc, 64'(p), 1'b1);
        mw_acc = model_acc(o, mw_acc, 64'(p), 1'b0);
        ms_ovf = nso;
        mw_ovf = nwo;
        m_cnt  = model_cnt(o, m_cnt);
        b.acc_s = ms_acc; b.ovf_s = ms_ovf;
        b.acc_w = mw_acc; b.ovf_w = mw_ovf;
        b.cnt   = m_cnt;
        q.push_back(b);
      end
      m_s1 = acc_now || (m_s1 && !adv);
    end
    took = acc_now;
  endtask

  task automatic idle(input int n, input bit ordy);
    bit t;
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd3, 32'd0, ordy, 1'b0, t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    bit got;

    // Reset
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("rst_in_ready", 64'(ifs.in_ready), 64'd1);
    chk("rst_out_valid", 64'(ifs.out_valid), 64'd0);
    chk("rst_acc", 64'(ifs.acc), 64'd0);
    chk("rst_ovf", 64'(ifw.overflow), 64'd0);
    chk("rst_count", 64'(ifw.count), 64'd0);

    // LOAD 6, ADD 0xC: first beat two edges after the first accept
    cycle(1'b1, 2'd0, 32'h6, 1'b1, 1'b0, t);
    chk("lat_not_yet", 64'(ifs.out_valid), 64'd0);
    cycle(1'b1, 2'd1, 32'hC, 1'b1, 1'b0, t);
    chk("lat_first_beat", 64'(ifs.out_valid), 64'd1);
    chk("lat_acc6", 64'(ifs.acc), 64'h6);
    idle(3, 1'b1);

    // Underflow on SUB: clamp vs wrap
    cycle(1'b1, 2'd0, 32'd5, 1'b1, 1'b0, t);
    cycle(1'b1, 2'd2, 32'd8, 1'b1, 1'b0, t);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("sub_acc_sat", 64'(ifs.acc), 64'd0);
    chk("sub_acc_wrap", 64'(ifw.acc), 64'hFF_FFFF_FFFD);
    chk("sub_ovf_sat", 64'(ifs.overflow), 64'd1);
    chk("sub_ovf_wrap", 64'(ifw.overflow), 64'd1);
    chk("sub_count", 64'(ifw.count), 64'd2);
    cycle(1'b1, 2'd1, 32'd3, 1'b1, 1'b0, t);
    cycle(1'b1, 2'd0, 32'd1, 1'b1, 1'b0, t);
    idle(3, 1'b1);

    // Back-pressure: LOAD 1, ADD 2, ADD 3 with out_ready low
    cycle(1'b1, 2'd0, 32'd1, 1'b0, 1'b0, t);
    cycle(1'b1, 2'd1, 32'd2, 1'b0, 1'b0, t);
    chk("bp_in_ready", 64'(ifs.in_ready), 64'd0);
    chk("bp_acc_held", 64'(ifs.acc), 64'd1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) cycle(1'b1, 2'd1, 32'd3, i >= 2, 1'b0, got);
    chk("bp_accept", 64'(got), 64'd1);
    idle(4, 1'b1);

    // clear while stage 1 holds ADD 0x100 and an output is presented
    cycle(1'b1, 2'd0, 32'd7, 1'b0, 1'b0, t);
    cycle(1'b1, 2'd1, 32'h100, 1'b0, 1'b0, t);
    chk("clr_pre_valid", 64'(ifs.out_valid), 64'd1);
    cycle(1'b0, 2'd3, 32'd0, 1'b0, 1'b1, t);
    drive(1'b0, 2'd3, 32'd0, 1'b1, 1'b0);
    #1;
    chk("clr_out_valid", 64'(ifs.out_valid), 64'd0);
    chk("clr_acc", 64'(ifw.acc), 64'd0);
    chk("clr_count", 64'(ifs.count), 64'd0);
    chk("clr_in_ready", 64'(ifs.in_ready), 64'd1);
    idle(3, 1'b1);

    // Randomised traffic with occasional clear
    for (int i = 0; i < 400; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : 32'($urandom);
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), p,
            $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, t);
    end
    idle(4, 1'b1);

    // Count saturation: LOAD 0 then 300 x ADD 1
    beats = 0;
    cycle(1'b1, 2'd0, 32'd0, 1'b1, 1'b0, t);
    for (int i = 0; i < 300; i++) begin
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) cycle(1'b1, 2'd1, 32'd1, 1'b1, 1'b0, got);
      if (!got) chk("stream_accept", 64'(got), 64'd1);
    end
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("stream_valid", 64'(ifs.out_valid), 64'd1);
    chk("stream_acc", 64'(ifs.acc), 64'd300);
    chk("stream_count", 64'(ifw.count), 64'd255);
    idle(3, 1'b1);
    chk("stream_beats", 64'(beats), 64'd301);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream stage for the 16x16 array multiplier.
- Takes each 32-bit unsigned product over a valid/ready handshake and loads, adds or subtracts it into a wide accumulator.
- Presents the accumulator, a sticky overflow flag and an operation count over an output valid/ready handshake.
- Two-stage pipeline: an input capture register followed by an accumulate/output register. Full throughput of 1 product/cycle when not back-pressured.

Parameters:
- PROD_W, 32, product width; matches the multiplier output.
- ACC_W, 40, accumulator width; must be ≥ PROD_W.
- CNT_W, 8, width of the operation counter.
- SATURATE, 1, 1 = clamp on overflow/underflow, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  product and op are valid.
- in_ready  out  1  block accepts the product this cycle.
- product  in  PROD_W  unsigned product from the multiplier.
- op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 PASS.
- clear  in  1  synchronous flush and zero.
- out_valid  out  1  acc, overflow and count are valid.
- out_ready  in  1  consumer accepts the output.
- acc  out  ACC_W  accumulator value.
- overflow  out  1  sticky overflow/underflow flag.
- count  out  CNT_W  ops applied since the last LOAD or clear; saturates at all-ones.

Behaviour:
- Reset (rst_n=0 at an edge):
  - s1_valid=0, out_valid=0, acc=0, overflow=0, count=0.
  - in_ready is 1 in the first cycle after reset is released.
- Stage 2 advance condition: adv = s1_valid & (!out_valid | out_ready).
- in_ready is combinational: !clear & (!s1_valid | adv). There is no combinational path from in_valid to in_ready.
- Input capture: on in_valid & in_ready, latch product and op into stage 1 and set s1_valid=1. Otherwise, if adv, clear s1_valid to 0.
- When adv, stage 2 executes the op on the stage-1 contents using an ACC_W+1-bit intermediate and sets out_valid=1:
  - LOAD: acc=zero-extended product; overflow=0; count=1.
  - ADD: sum=acc+product. If sum[ACC_W]=1: overflow=1, and acc becomes all-ones (SATURATE=1) or sum[ACC_W-1:0] (SATURATE=0). count+1.
  - SUB: if product>acc: overflow=1, and acc becomes 0 (SATURATE=1) or (acc-product) mod 2^ACC_W (SATURATE=0). Otherwise acc=acc-product. count+1.
  - PASS: acc and overflow unchanged; count unchanged; a fresh output beat is still produced.
- If out_ready is asserted and no adv occurs, out_valid clears to 0.
- While out_valid & !out_ready, acc, overflow and count are held stable.
- Latency: a product accepted at edge k is reflected in acc with out_valid=1 after edge k+1.
- Under back-pressure the pipeline holds at most 2 products: one in stage 1, one presented. in_ready=0 until the output drains. No data is lost or duplicated.
- clear=1 at an edge:
  - s1_valid=0, out_valid=0, acc=0, overflow=0, count=0.
  - Any in-flight product is discarded. clear has priority over all inputs. in_ready=0 during the clear cycle.
- rst_n=0 mid-operation has the same effect as clear, and additionally overrides clear.
- count saturates at 2^CNT_W-1; it never wraps.

Decomposition:
- Package mac_pkg:
  - op encoding constants OP_LOAD, OP_ADD, OP_SUB, OP_PASS.
  - default PROD_W, ACC_W, CNT_W.
- One combinational sub-module, acc_alu: (acc, product, op, SATURATE) → (next_acc, ovf_event). Isolates the arithmetic for unit testing.
- Pipeline registers and handshake logic stay in mac_accumulator.

Test Plan:
- Reset, then LOAD 0x0000_0006 followed by ADD 0x0000_000C with out_ready=1 → out_valid beats show acc=0x6 then acc=0x12, count=1 then 2, overflow=0. First output appears 2 edges after the first accept.
- SATURATE=1: LOAD 5, then SUB 8 → acc=0, overflow=1. A subsequent ADD 3 gives acc=3 with overflow still 1. A LOAD 1 clears overflow to 0.
- SATURATE=0: LOAD 5, then SUB 8 → acc=0xFF_FFFF_FFFD, overflow=1, count=2.
- Back-pressure: out_ready=0 while streaming LOAD 1, ADD 2, ADD 3 back-to-back:
  - after the second accept, in_ready=0 and acc=1 is held;
  - release out_ready → beats acc=1, 3, 6 in order, none dropped.
- clear asserted while stage 1 holds ADD 0x100 and out_valid=1 → next cycle out_valid=0, acc=0, count=0, in_ready=1, and the ADD is never applied.
- Streaming 300 ADD 1 after LOAD 0 with out_ready=1 → count sticks at 255, acc=300, one output beat per input.
